// File: rtl/timer.sv
// 32-bit timer/counter with prescaler, compare match and sticky MATCH flag,
// exposed as an AXI4-Lite subordinate with a level interrupt (irq = MATCH & IE).
module timer #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [WIDTH/8-1:0]    wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [WIDTH-1:0]      rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  irq
);

   localparam int NSTRB = WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                    input logic [WIDTH-1:0] new_v,
                                                    input logic [NSTRB-1:0] strb);
      logic [WIDTH-1:0] res;
      res = old_v;
      for (int i = 0; i < NSTRB; i++)
         if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   logic             en, oneshot, ie, match;
   logic [15:0]      prescale, pcnt;
   logic [WIDTH-1:0] compare, count;

   logic             aw_held, w_held;
   logic [2:0]       aw_idx_q;
   logic [WIDTH-1:0] w_data_q;
   logic [NSTRB-1:0] w_strb_q;

   logic             wr_go, wr_mapped, rd_mapped;
   logic             wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status, w1c;
   logic             tick, hit;
   logic [2:0]       rd_idx;
   logic [WIDTH-1:0] ctrl_new, pre_new, cmp_new, cnt_new, rd_val;
   logic             unused_bits;

   assign awready = !aw_held && !bvalid;
   assign wready  = !w_held && !bvalid;
   assign arready = !rvalid;
   assign irq     = match & ie;

   // The write commits on the edge after both halves have been latched.
   assign wr_go       = aw_held && w_held;
   assign wr_mapped   = (aw_idx_q <= 3'd4);
   assign wr_ctrl     = wr_go && (aw_idx_q == 3'd0);
   assign wr_prescale = wr_go && (aw_idx_q == 3'd1);
   assign wr_compare  = wr_go && (aw_idx_q == 3'd2);
   assign wr_count    = wr_go && (aw_idx_q == 3'd3);
   assign wr_status   = wr_go && (aw_idx_q == 3'd4);
   assign w1c         = wr_status && w_strb_q[0] && w_data_q[0];

   assign ctrl_new = merge_bytes({{(WIDTH-3){1'b0}}, ie, oneshot, en}, w_data_q, w_strb_q);
   assign pre_new  = merge_bytes({{(WIDTH-16){1'b0}}, prescale}, w_data_q, w_strb_q);
   assign cmp_new  = merge_bytes(compare, w_data_q, w_strb_q);
   assign cnt_new  = merge_bytes(count, w_data_q, w_strb_q);

   assign tick = en && (pcnt == prescale);
   assign hit  = tick && (count == compare);

   assign rd_idx    = araddr[4:2];
   assign rd_mapped = (rd_idx <= 3'd4);

   assign unused_bits = ^{awaddr[1:0], araddr[1:0], ctrl_new[WIDTH-1:3], pre_new[WIDTH-1:16]};

   always_comb begin
      rd_val = '0;
      case (rd_idx)
         3'd0:    rd_val[2:0]  = {ie, oneshot, en};
         3'd1:    rd_val[15:0] = prescale;
         3'd2:    rd_val       = compare;
         3'd3:    rd_val       = count;
         3'd4:    rd_val[0]    = match;
         default: rd_val       = '0;
      endcase
   end

   // Timer core: software writes override the same-edge hardware update,
   // except a hardware MATCH set beats a W1C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en       <= 1'b0;
         oneshot  <= 1'b0;
         ie       <= 1'b0;
         match    <= 1'b0;
         prescale <= '0;
         pcnt     <= '0;
         compare  <= '1;
         count    <= '0;
      end else begin
         if (!en || wr_prescale || tick) pcnt <= '0;
         else                            pcnt <= pcnt + 16'd1;

         if (wr_ctrl) begin
            en      <= ctrl_new[0];
            oneshot <= ctrl_new[1];
            ie      <= ctrl_new[2];
         end else if (hit && oneshot) begin
            en <= 1'b0;
         end

         if (wr_prescale) prescale <= pre_new[15:0];
         if (wr_compare)  compare  <= cmp_new;

         if (wr_count)  count <= cnt_new;
         else if (hit)  count <= '0;
         else if (tick) count <= count + 1'b1;

         if (hit)      match <= 1'b1;
         else if (w1c) match <= 1'b0;
      end
   end

   // AXI channel state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
         bvalid   <= 1'b0;
         bresp    <= RESP_OKAY;
         rvalid   <= 1'b0;
         rdata    <= '0;
         rresp    <= RESP_OKAY;
      end else begin
         if (awvalid && awready) begin
            aw_held  <= 1'b1;
            aw_idx_q <= awaddr[4:2];
         end
         if (wvalid && wready) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
         if (wr_go) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end

         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: reset, periodic/one-shot counting, AXI ordering,
// byte strobes, unmapped access and same-edge collisions.
module tb_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   timer #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      logic aw_hs, w_hs, got;
      got = 1'b0;
      resp = 2'b11;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         step();
         if (aw_hs) awvalid = 1'b0;
         if (w_hs)  wvalid  = 1'b0;
         if (bvalid) begin
            got  = 1'b1;
            resp = bresp;
         end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check_b("write_done", got, 1'b1);
      step();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      logic hs, got;
      got = 1'b0;
      d = '0; resp = 2'b11;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
         hs = arvalid && arready;
         step();
         if (hs) arvalid = 1'b0;
         if (rvalid) begin
            got  = 1'b1;
            d    = rdata;
            resp = rresp;
         end
      end
      arvalid = 1'b0;
      check_b("read_done", got, 1'b1);
      step();
      rready = 1'b0;
   endtask

   task automatic wait_irq(input int limit);
      for (int n = 0; n < limit && !irq; n++) step();
   endtask

   logic [31:0] rd;
   logic [1:0]  rr, br;
   int          cyc_en, cyc_m1;

   initial begin
      rst = 1'b1;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset in the middle of a write: AW accepted, W still pending
      awaddr = 5'h0C; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      check_b("aw_held_blocks_awready", awready, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_b("async_rst_awready", awready, 1'b1);
      step();
      rst = 1'b0;
      step();
      check_b("rst_bvalid", bvalid, 1'b0);
      check_b("rst_rvalid", rvalid, 1'b0);
      check_b("rst_irq", irq, 1'b0);
      check_b("rst_awready", awready, 1'b1);
      check_b("rst_wready", wready, 1'b1);
      check_b("rst_arready", arready, 1'b1);
      axi_read(5'h08, rd, rr);
      check("rst_compare", rd, 32'hFFFF_FFFF);
      axi_read(5'h0C, rd, rr);
      check("rst_count", rd, 32'h0);

      // Periodic: tick every 4 cycles, match on the 5th tick
      axi_write(5'h04, 32'd3, 4'hF, br);
      axi_write(5'h08, 32'd4, 4'hF, br);
      axi_write(5'h00, 32'h5, 4'hF, br);
      cyc_en = cyc - 1;
      wait_irq(40);
      check_b("per_irq_rise", irq, 1'b1);
      check("per_first_match_cycles", 32'(cyc - cyc_en), 32'd20);
      cyc_m1 = cyc;
      axi_read(5'h0C, rd, rr);
      check("per_count_after_match", rd, 32'h0);
      axi_read(5'h10, rd, rr);
      check("per_status_match", rd, 32'h1);
      axi_write(5'h10, 32'h1, 4'hF, br);
      check_b("per_w1c_irq_low", irq, 1'b0);
      wait_irq(40);
      check_b("per_irq_second", irq, 1'b1);
      check("per_second_match_cycles", 32'(cyc - cyc_m1), 32'd20);
      axi_write(5'h00, 32'h0, 4'hF, br);
      axi_write(5'h10, 32'h1, 4'hF, br);
      check_b("per_off_irq", irq, 1'b0);

      // One-shot: PRESCALE=0, COMPARE=2 -> match 3 cycles after EN, EN self-clears
      axi_write(5'h04, 32'd0, 4'hF, br);
      axi_write(5'h0C, 32'd0, 4'hF, br);
      axi_write(5'h08, 32'd2, 4'hF, br);
      axi_write(5'h00, 32'h3, 4'hF, br);
      cyc_en = cyc - 1;
      for (int n = 0; n < 20 && !dut.match; n++) step();
      check_b("os_match", dut.match, 1'b1);
      check("os_match_cycles", 32'(cyc - cyc_en), 32'd3);
      axi_read(5'h00, rd, rr);
      check("os_ctrl", rd, 32'h2);
      repeat (10) step();
      axi_read(5'h0C, rd, rr);
      check("os_count_stopped", rd, 32'h0);
      axi_read(5'h10, rd, rr);
      check("os_status", rd, 32'h1);
      axi_write(5'h10, 32'h1, 4'hF, br);

      // AXI ordering: W three cycles ahead of AW, bready held low
      bready = 1'b0;
      wdata = 32'h0000_1234; wstrb = 4'hF; wvalid = 1'b1;
      check_b("ord_wready_pre", wready, 1'b1);
      step();
      wvalid = 1'b0;
      check_b("ord_wready_after_hs", wready, 1'b0);
      step();
      step();
      check_b("ord_no_bvalid_w_only", bvalid, 1'b0);
      awaddr = 5'h08; awvalid = 1'b1;
      check_b("ord_awready_pre", awready, 1'b1);
      step();
      awvalid = 1'b0;
      check_b("ord_awready_held", awready, 1'b0);
      step();
      check_b("ord_bvalid_rise", bvalid, 1'b1);
      check("ord_bresp", 32'(bresp), 32'd0);
      for (int n = 0; n < 3; n++) begin
         step();
         check_b("ord_bvalid_hold", bvalid, 1'b1);
         check_b("ord_awready_low", awready, 1'b0);
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      check_b("ord_bvalid_fall", bvalid, 1'b0);
      check_b("ord_awready_back", awready, 1'b1);
      axi_read(5'h08, rd, rr);
      check("ord_compare", rd, 32'h0000_1234);

      // Byte strobes and unmapped offsets
      axi_write(5'h0C, 32'h0, 4'hF, br);
      axi_write(5'h0C, 32'hAABB_CCDD, 4'b0101, br);
      check("strb_bresp", 32'(br), 32'd0);
      axi_read(5'h0C, rd, rr);
      check("strb_count", rd, 32'h00BB_00DD);
      axi_read(5'h18, rd, rr);
      check("unmapped_rresp", 32'(rr), 32'h2);
      check("unmapped_rdata", rd, 32'h0);
      axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF, br);
      check("unmapped_bresp", 32'(br), 32'h2);
      axi_read(5'h08, rd, rr);
      check("unmapped_no_effect", rd, 32'h0000_1234);

      // Collision: COUNT write on a tick edge (PRESCALE=0 ticks every cycle)
      axi_write(5'h08, 32'd1000, 4'hF, br);
      axi_write(5'h00, 32'h1, 4'hF, br);
      awaddr = 5'h0C; wdata = 32'd7; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      step();
      check_b("coll_bvalid", bvalid, 1'b1);
      araddr = 5'h0C; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
      step();
      arvalid = 1'b0;
      check_b("coll_rvalid", rvalid, 1'b1);
      check("coll_count_written", rdata, 32'd7);
      step();
      rready = 1'b0; bready = 1'b0;

      // Collision: W1C while COMPARE=0 matches on every tick
      axi_write(5'h00, 32'h0, 4'hF, br);
      axi_write(5'h08, 32'h0, 4'hF, br);
      axi_write(5'h0C, 32'h0, 4'hF, br);
      axi_write(5'h00, 32'h5, 4'hF, br);
      axi_write(5'h10, 32'h1, 4'hF, br);
      axi_read(5'h10, rd, rr);
      check("coll_match_wins", rd, 32'h1);
      check_b("coll_irq", irq, 1'b1);
      axi_write(5'h00, 32'h4, 4'hF, br);
      axi_write(5'h10, 32'h1, 4'h0, br);
      axi_read(5'h10, rd, rr);
      check("w1c_needs_strb0", rd, 32'h1);
      axi_write(5'h10, 32'h1, 4'h1, br);
      axi_read(5'h10, rd, rr);
      check("w1c_clears", rd, 32'h0);
      check_b("w1c_irq_low", irq, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
